// File: rtl/i2s_tx.sv
// I2S transmit serializer: buffers one stereo pair and shifts it out MSB-first on sd, framed by sck/ws.
// Optional macro I2S_TX_UNDERRUN_EN enables the registered underrun pulse; otherwise underrun is tied 0.
module i2s_tx #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             ws,
    input  logic [WIDTH-1:0] input_l_tdata,
    input  logic [WIDTH-1:0] input_r_tdata,
    input  logic             input_tvalid,
    output logic             input_tready,
    output logic             sd,
    output logic             underrun
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] l_buf;
    logic [WIDTH-1:0] r_buf;
    logic             l_valid;
    logic             r_valid;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             sck_last;
    logic             ws_last;

    logic fall_c;
    logic ws_edge_c;
    logic load_l_c;
    logic load_r_c;
    logic handshake_c;
    logic l_valid_nxt_c;
    logic r_valid_nxt_c;

    // Bit-clock falling edge and word-select transitions, seen in the clk domain
    assign fall_c      = sck_last & ~sck;
    assign ws_edge_c   = fall_c & (ws != ws_last);
    assign load_l_c    = ws_edge_c & ~ws;
    assign load_r_c    = ws_edge_c & ws;
    assign handshake_c = input_tvalid & input_tready;

    // A handshake only happens with both halves empty, so setting wins over a same-cycle load clear
    always_comb begin
        l_valid_nxt_c = l_valid;
        r_valid_nxt_c = r_valid;
        if (load_l_c) begin
            l_valid_nxt_c = 1'b0;
        end
        if (load_r_c) begin
            r_valid_nxt_c = 1'b0;
        end
        if (handshake_c) begin
            l_valid_nxt_c = 1'b1;
            r_valid_nxt_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_buf        <= '0;
            r_buf        <= '0;
            l_valid      <= 1'b0;
            r_valid      <= 1'b0;
            sreg         <= '0;
            bit_cnt      <= '0;
            sck_last     <= 1'b0;
            ws_last      <= 1'b0;
            sd           <= 1'b0;
            input_tready <= 1'b1;
        end else begin
            sck_last     <= sck;
            l_valid      <= l_valid_nxt_c;
            r_valid      <= r_valid_nxt_c;
            input_tready <= ~l_valid_nxt_c & ~r_valid_nxt_c;

            if (handshake_c) begin
                l_buf <= input_l_tdata;
                r_buf <= input_r_tdata;
            end

            // Shift first so a same-edge load still emits the old LSB, then overwrite with the new word
            if (fall_c) begin
                ws_last <= ws;
                if (bit_cnt != '0) begin
                    sd      <= sreg[WIDTH-1];
                    sreg    <= {sreg[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt - CNT_W'(1);
                end else begin
                    sd <= 1'b0;
                end
                if (ws_edge_c) begin
                    bit_cnt <= CNT_W'(WIDTH);
                    if (ws) begin
                        sreg <= r_valid ? r_buf : '0;
                    end else begin
                        sreg <= l_valid ? l_buf : '0;
                    end
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_EN
    // One pulse per channel load that found its buffer half empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else begin
            underrun <= (load_l_c & ~l_valid) | (load_r_c & ~r_valid);
        end
    end
`else
    assign underrun = 1'b0;
`endif

endmodule
